// File: rtl/rv32_wb_pkg.sv
// Shared types and constants for the register-file writeback arbiter.
//   REG_COUNT   number of architectural integer registers (x0..x31)
//   REG_ADDR_W  register index width
//   XLEN        register data width
//   wb_entry_t  one queued writeback: valid flag, destination register, value
//   wb_src_t    which source drives the regfile write port in a given cycle
//   reg_onehot  one-hot decode of a register index into a REG_COUNT-bit mask
package rv32_wb_pkg;

    localparam int REG_COUNT  = 32;
    localparam int REG_ADDR_W = $clog2(REG_COUNT);
    localparam int XLEN       = 32;

    typedef struct packed {
        logic                  valid;
        logic [REG_ADDR_W-1:0] rd;
        logic [XLEN-1:0]       value;
    } wb_entry_t;

    typedef enum logic [1:0] {
        SRC_NONE,
        SRC_PIPE,
        SRC_FIFO,
        SRC_BYPASS
    } wb_src_t;

    function automatic logic [REG_COUNT-1:0] reg_onehot(input logic [REG_ADDR_W-1:0] rd);
        return REG_COUNT'(1) << rd;
    endfunction

endpackage

// File: rtl/rv32_wb_fifo.sv
// Queue of long-latency writeback results awaiting a free regfile write slot.
// Entries keep arrival order. A newer in-order write to the same register can
// invalidate queued entries in place; an invalidated entry still occupies its
// slot until it reaches the head and is popped.
// Ports:
//   clk, reset             clock; synchronous active-high reset
//   push/push_rd/push_value append an entry at the tail (never asserted when full)
//   pop                     remove the head entry (never asserted when empty)
//   inval/inval_rd          clear the valid flag of every live entry targeting inval_rd
//   head                    current head entry (valid=0 when empty or invalidated)
//   full/empty/count        occupancy, live plus invalidated entries, 0..DEPTH
//   pending_mask            bit n set while a valid entry targets xn; bit 0 always 0
module rv32_wb_fifo
    import rv32_wb_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   push,
    input  logic [REG_ADDR_W-1:0]  push_rd,
    input  logic [XLEN-1:0]        push_value,
    input  logic                   pop,
    input  logic                   inval,
    input  logic [REG_ADDR_W-1:0]  inval_rd,
    output wb_entry_t              head,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count,
    output logic [REG_COUNT-1:0]   pending_mask
);

    localparam int PTR_W = $clog2(DEPTH);

    wb_entry_t        entries [DEPTH];
    logic [PTR_W-1:0] head_ptr;
    logic [PTR_W-1:0] tail_ptr;
    logic [PTR_W:0]   count_q;

    // Valid flags are cleared on pop, so a set flag always means "live and not
    // superseded"; the mask and head checks never need to consult the pointers.
    always_ff @(posedge clk) begin
        if (reset) begin
            head_ptr <= '0;
            tail_ptr <= '0;
            count_q  <= '0;
            // NOTE: only the valid flags are reset; rd/value of an invalid slot are
            // never observed, so the payload storage stays reset-free.
            for (int i = 0; i < DEPTH; i++) begin
                entries[i].valid <= 1'b0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (inval && entries[i].valid && (entries[i].rd == inval_rd)) begin
                    entries[i].valid <= 1'b0;
                end
            end
            if (pop) begin
                entries[head_ptr].valid <= 1'b0;
                head_ptr                <= head_ptr + 1'b1;
            end
            // The tail slot is never live when pushing, so this write cannot collide
            // with the invalidate above; a same-cycle push is never invalidated.
            if (push) begin
                entries[tail_ptr] <= '{valid: 1'b1, rd: push_rd, value: push_value};
                tail_ptr          <= tail_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    assign head  = entries[head_ptr];
    assign count = count_q;
    assign full  = (count_q == (PTR_W+1)'(DEPTH));
    assign empty = (count_q == '0);

    always_comb begin
        // NOTE: assign a default before the loop so every path drives the mask and
        // no latch is inferred.
        pending_mask = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (entries[i].valid) begin
                pending_mask = pending_mask | reg_onehot(entries[i].rd);
            end
        end
        pending_mask[0] = 1'b0;
    end

endmodule

// File: rtl/rv32_wb_arbiter.sv
// Register-file write port arbiter. The in-order pipeline has no backpressure
// and always wins the port; long-latency results (load/mul/div) are queued and
// drain in cycles the pipeline leaves idle, or bypass the queue when it is empty.
// Ports:
//   clk, reset                   clock; synchronous active-high reset
//   pipe_rd_in / _writeback_in / _value_in   pipeline writeback request
//   mc_valid_in, mc_ready_out    long-latency handshake (transfer = valid && ready)
//   mc_rd_in, mc_value_in        long-latency result
//   rd_out / rd_writeback_out / rd_value_out registered regfile write port
//   pending_mask_out             registers with a queued, still-valid write
module rv32_wb_arbiter
    import rv32_wb_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [4:0]            pipe_rd_in,
    input  logic                  pipe_rd_writeback_in,
    input  logic [31:0]           pipe_rd_value_in,
    input  logic                  mc_valid_in,
    output logic                  mc_ready_out,
    input  logic [4:0]            mc_rd_in,
    input  logic [31:0]           mc_value_in,
    output logic [4:0]            rd_out,
    output logic                  rd_writeback_out,
    output logic [31:0]           rd_value_out,
    output logic [REG_COUNT-1:0]  pending_mask_out
);

    wb_entry_t              head;
    logic                   fifo_full;
    logic                   fifo_empty;
    logic [$clog2(DEPTH):0] fifo_count;
    logic                   fifo_push;
    logic                   fifo_pop;

    logic    active_q;
    logic    pipe_write;
    logic    mc_write;
    logic    head_dead;
    wb_src_t src;

    // Ready depends only on flops: active_q keeps it low through reset, and a pop
    // from a full queue raises it one cycle later, when the count has dropped.
    assign mc_ready_out = active_q && !fifo_full;

    // Writes to x0 are dropped here; an x0 mc transfer still completes its handshake.
    assign pipe_write = pipe_rd_writeback_in && (pipe_rd_in != '0);
    assign mc_write   = mc_valid_in && mc_ready_out && (mc_rd_in != '0);

    // A superseded head is discarded without using the write port, so it can be
    // popped even while the pipeline owns the port.
    assign head_dead = (fifo_count != '0) && !head.valid;

    always_comb begin
        src = SRC_NONE;
        if (pipe_write) begin
            src = SRC_PIPE;
        end else if (head.valid) begin
            src = SRC_FIFO;
        end else if (fifo_empty && mc_write) begin
            // Bypass only with nothing queued, so mc results never overtake each other.
            src = SRC_BYPASS;
        end
    end

    assign fifo_pop  = head_dead || (src == SRC_FIFO);
    assign fifo_push = mc_write && (src != SRC_BYPASS);

    rv32_wb_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk          (clk),
        .reset        (reset),
        .push         (fifo_push),
        .push_rd      (mc_rd_in),
        .push_value   (mc_value_in),
        .pop          (fifo_pop),
        .inval        (pipe_write),
        .inval_rd     (pipe_rd_in),
        .head         (head),
        .full         (fifo_full),
        .empty        (fifo_empty),
        .count        (fifo_count),
        .pending_mask (pending_mask_out)
    );

    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // the pre-edge values of the others.
    always_ff @(posedge clk) begin
        if (reset) begin
            active_q         <= 1'b0;
            rd_out           <= '0;
            rd_writeback_out <= 1'b0;
            rd_value_out     <= '0;
        end else begin
            active_q         <= 1'b1;
            rd_writeback_out <= (src != SRC_NONE);
            // Address and data hold their previous values in idle cycles.
            case (src)
                SRC_PIPE: begin
                    rd_out       <= pipe_rd_in;
                    rd_value_out <= pipe_rd_value_in;
                end
                SRC_FIFO: begin
                    rd_out       <= head.rd;
                    rd_value_out <= head.value;
                end
                SRC_BYPASS: begin
                    rd_out       <= mc_rd_in;
                    rd_value_out <= mc_value_in;
                end
                default: begin
                    rd_out       <= rd_out;
                    rd_value_out <= rd_value_out;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rv32_wb_arbiter.sv
// Self-checking bench for rv32_wb_arbiter: directed scenarios followed by a
// random phase, all compared against a queue-based reference model.
module tb_rv32_wb_arbiter;
    import rv32_wb_pkg::*;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic [4:0]  pipe_rd;
    logic        pipe_rd_writeback;
    logic [31:0] pipe_rd_value;
    logic        mc_valid;
    logic        mc_ready;
    logic [4:0]  mc_rd;
    logic [31:0] mc_value;
    logic [4:0]  rd;
    logic        rd_writeback;
    logic [31:0] rd_value;
    logic [31:0] pending_mask;

    int checks = 0;
    int passed = 0;
    int failed = 0;

    always #5 clk = ~clk;

    rv32_wb_arbiter #(
        .DEPTH (DEPTH)
    ) dut (
        .clk                  (clk),
        .reset                (reset),
        .pipe_rd_in           (pipe_rd),
        .pipe_rd_writeback_in (pipe_rd_writeback),
        .pipe_rd_value_in     (pipe_rd_value),
        .mc_valid_in          (mc_valid),
        .mc_ready_out         (mc_ready),
        .mc_rd_in             (mc_rd),
        .mc_value_in          (mc_value),
        .rd_out               (rd),
        .rd_writeback_out     (rd_writeback),
        .rd_value_out         (rd_value),
        .pending_mask_out     (pending_mask)
    );

    // Reference model: queue of waiting results in arrival order, plus the
    // expected regfile write port.
    wb_entry_t   q[$];
    logic        m_active;
    logic        m_we;
    logic [4:0]  m_rd;
    logic [31:0] m_val;

    function automatic logic [31:0] model_mask();
        logic [31:0] m = '0;
        foreach (q[i]) if (q[i].valid) m[q[i].rd] = 1'b1;
        return m;
    endfunction

    function automatic logic model_ready();
        return m_active && (q.size() < DEPTH);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) begin
            passed++;
        end else begin
            failed++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One clock: drive inputs at negedge, predict, check the port after the edge.
    task automatic cycle(input logic pw, input logic [4:0] prd, input logic [31:0] pv,
                         input logic mv, input logic [4:0] mrd, input logic [31:0] mval,
                         output logic acc);
        logic live_mc;
        logic bypassed;
        logic drop_head;
        @(negedge clk);
        pipe_rd_writeback = pw;
        pipe_rd           = prd;
        pipe_rd_value     = pv;
        mc_valid          = mv;
        mc_rd             = mrd;
        mc_value          = mval;
        check("ready", {31'b0, mc_ready}, {31'b0, model_ready()});
        acc      = mv && model_ready();
        live_mc  = acc && (mrd != 5'd0);
        bypassed = 1'b0;
        m_we     = 1'b0;
        if (pw && prd != 5'd0) begin
            m_we = 1'b1; m_rd = prd; m_val = pv;
            drop_head = (q.size() > 0) && !q[0].valid;
            foreach (q[i]) if (q[i].rd == prd) q[i].valid = 1'b0;
            if (drop_head) void'(q.pop_front());
        end else if (q.size() > 0) begin
            if (q[0].valid) begin
                m_we = 1'b1; m_rd = q[0].rd; m_val = q[0].value;
            end
            void'(q.pop_front());
        end else if (live_mc) begin
            m_we = 1'b1; m_rd = mrd; m_val = mval; bypassed = 1'b1;
        end
        if (live_mc && !bypassed) q.push_back('{valid: 1'b1, rd: mrd, value: mval});
        @(posedge clk);
        #1;
        check("we",    {31'b0, rd_writeback}, {31'b0, m_we});
        check("rd",    {27'b0, rd}, {27'b0, m_rd});
        check("value", rd_value, m_val);
        check("mask",  pending_mask, model_mask());
    endtask

    task automatic idle(input int n);
        logic acc;
        repeat (n) cycle(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, acc);
    endtask

    task automatic do_reset(input int n);
        @(negedge clk);
        reset = 1'b1;
        pipe_rd_writeback = 1'b0; pipe_rd = '0; pipe_rd_value = '0;
        mc_valid = 1'b0; mc_rd = '0; mc_value = '0;
        repeat (n) @(posedge clk);
        #1;
        q.delete();
        m_active = 1'b0; m_we = 1'b0; m_rd = '0; m_val = '0;
        check("rst_we",    {31'b0, rd_writeback}, 32'd0);
        check("rst_rd",    {27'b0, rd}, 32'd0);
        check("rst_value", rd_value, 32'd0);
        check("rst_mask",  pending_mask, 32'd0);
        check("rst_ready", {31'b0, mc_ready}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        check("rel_ready_low", {31'b0, mc_ready}, 32'd0);
        @(posedge clk);
        #1;
        m_active = 1'b1;
        check("rel_ready_high", {31'b0, mc_ready}, 32'd1);
        check("rel_mask", pending_mask, 32'd0);
        check("rel_we", {31'b0, rd_writeback}, 32'd0);
    endtask

    initial begin
        logic acc;
        int   k;
        int   exp_next;

        // Reset and release
        do_reset(3);

        // Pipeline write only
        cycle(1'b1, 5'd5, 32'h1234, 1'b0, 5'd0, 32'd0, acc);
        check("pipe_x5_rd", {27'b0, rd}, 32'd5);
        check("pipe_x5_value", rd_value, 32'h1234);

        // mc bypass with idle pipe and empty queue
        cycle(1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 32'hAA, acc);
        check("bypass_acc", {31'b0, acc}, 32'd1);
        check("bypass_rd", {27'b0, rd}, 32'd7);
        check("bypass_value", rd_value, 32'hAA);
        check("bypass_mask", pending_mask, 32'd0);

        // Pipe busy x1..x6 while mc offers x8..x12
        k = 0;
        for (int i = 0; i < 6; i++) begin
            cycle(1'b1, 5'(i + 1), 32'(100 + i), (k < 5), 5'(8 + k), 32'(32'h800 + k), acc);
            if (acc) k++;
            if (i == 3) check("full_mask", pending_mask, 32'h0F00);
        end
        check("full_pushes", k, 4);
        check("full_ready", {31'b0, mc_ready}, 32'd0);
        exp_next = 8;
        for (int j = 0; j < 8; j++) begin
            cycle(1'b0, 5'd0, 32'd0, (k < 5), 5'(8 + k), 32'(32'h800 + k), acc);
            if (acc) k++;
            if (rd_writeback) begin
                check("drain_order", {27'b0, rd}, exp_next);
                exp_next++;
            end
        end
        check("drain_count", exp_next, 13);

        // WAW: queued x3=0x11 superseded by pipe x3=0x22
        cycle(1'b1, 5'd1, 32'h55, 1'b1, 5'd3, 32'h11, acc);
        check("waw_mask_set", pending_mask, 32'h8);
        cycle(1'b1, 5'd3, 32'h22, 1'b0, 5'd0, 32'd0, acc);
        check("waw_value", rd_value, 32'h22);
        check("waw_mask_clr", pending_mask, 32'h0);
        for (int j = 0; j < 3; j++) begin
            idle(1);
            check("waw_no_stale", {31'b0, rd_writeback}, 32'd0);
        end

        // x0 filter on both sources
        cycle(1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 32'h99, acc);
        check("x0_mc_acc", {31'b0, acc}, 32'd1);
        check("x0_mc_we", {31'b0, rd_writeback}, 32'd0);
        cycle(1'b1, 5'd0, 32'h77, 1'b0, 5'd0, 32'd0, acc);
        check("x0_pipe_we", {31'b0, rd_writeback}, 32'd0);
        check("x0_mask", pending_mask, 32'd0);

        // Same-cycle push to the register being overwritten survives
        cycle(1'b1, 5'd4, 32'h40, 1'b1, 5'd6, 32'h61, acc);
        cycle(1'b1, 5'd6, 32'h62, 1'b1, 5'd6, 32'h63, acc);
        check("waw_push_mask", pending_mask, 32'h40);
        idle(1);
        idle(1);
        check("waw_push_value", rd_value, 32'h63);

        // Reset mid-drain discards queued entries
        cycle(1'b1, 5'd1, 32'h1, 1'b1, 5'd9, 32'h9, acc);
        cycle(1'b1, 5'd2, 32'h2, 1'b1, 5'd10, 32'hA, acc);
        do_reset(2);
        for (int j = 0; j < 3; j++) begin
            idle(1);
            check("post_rst_we", {31'b0, rd_writeback}, 32'd0);
        end

        // Random traffic
        for (int n = 0; n < 400; n++) begin
            cycle(1'($urandom_range(1)), 5'($urandom_range(7)), $urandom,
                  1'($urandom_range(1)), 5'($urandom_range(7)), $urandom, acc);
        end
        idle(8);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
